// File: rtl/bus_test_pkg.sv
// ---------------------------------------------------------------------------
// bus_test_pkg
// Shared definitions for the RPI parallel-bus test blocks. It provides the
// bus width, the 2-bit state encoding of the transfer sequencer and the bit
// positions of the status LEDs.
// ---------------------------------------------------------------------------
package bus_test_pkg;

    localparam int BUS_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CSUM = 2'd2
    } state_e;

    // The completed-transfer count occupies [LED_CNT_HI:LED_CNT_LO].
    localparam int LED_CNT_LO = 0;
    localparam int LED_CNT_HI = 1;
    localparam int LED_ABORT  = 2;
    localparam int LED_BUSY   = 3;

endpackage

// File: rtl/bus_sync_edge.sv
// ---------------------------------------------------------------------------
// bus_sync_edge
// This module brings the asynchronous RPI bus strobe, the direction pin and
// the data pins into the system clock domain through SYNC_STAGES flops each.
// It produces single-cycle rise/fall pulses of the synchronised strobe.
// Data and direction come out of the same stage as the strobe, so they are
// valid on the cycle an edge pulse is seen. The write-direction test also
// uses this module.
//
// Ports
//   clk_i       system clock
//   rst_n_i     asynchronous active-low reset
//   bus_clk_i   raw RPI strobe
//   bus_rnw_i   raw direction pin
//   bus_data_i  raw data pins
//   rnw_s_o     synchronised direction
//   data_s_o    synchronised data
//   rise_o      strobe rising edge pulse
//   fall_o      strobe falling edge pulse
// ---------------------------------------------------------------------------
module bus_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter int W           = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         bus_clk_i,
    input  logic         bus_rnw_i,
    input  logic [W-1:0] bus_data_i,
    output logic         rnw_s_o,
    output logic [W-1:0] data_s_o,
    output logic         rise_o,
    output logic         fall_o
);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] rnw_sync_q;
    logic [W-1:0]           data_sync_q [SYNC_STAGES];
    logic                   clk_prev_q;
    logic                   clk_s;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_sync_q <= '0;
            rnw_sync_q <= '0;
            clk_prev_q <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_sync_q[i] <= '0;
            end
        end else begin
            clk_sync_q     <= {clk_sync_q[SYNC_STAGES-2:0], bus_clk_i};
            rnw_sync_q     <= {rnw_sync_q[SYNC_STAGES-2:0], bus_rnw_i};
            data_sync_q[0] <= bus_data_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_sync_q[i] <= data_sync_q[i-1];
            end
            clk_prev_q     <= clk_s;
        end
    end

    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign rnw_s_o  = rnw_sync_q[SYNC_STAGES-1];
    assign data_s_o = data_sync_q[SYNC_STAGES-1];
    assign rise_o   = clk_s & ~clk_prev_q;
    assign fall_o   = ~clk_s & clk_prev_q;

endmodule

// File: rtl/bus_tx_seq_test.sv
// ---------------------------------------------------------------------------
// bus_tx_seq_test
// This block runs the FPGA-to-RPI read-direction test for the RPI parallel
// bus. The RPI writes a seed byte. It then reads NUM_BYTES sequential bytes
// (seed, seed+1, ... mod 256) followed by their 8-bit checksum.
//
// Ports
//   clk_100mhz  system clock
//   reset_n     asynchronous active-low reset
//   bus_clk     RPI strobe (asynchronous)
//   bus_data    shared data bus, driven only while bus_rnw = 1
//   bus_rnw     1 = RPI reads, 0 = RPI writes
//   led_out     [1:0] completed transfers mod 4, [2] sticky abort, [3] busy
//
// state | meaning
// IDLE  | waiting for a seed write; read edges ignored, data_out holds
// SEND  | presenting data byte cnt; advance on each read falling edge
// CSUM  | presenting checksum; next read fall completes the transfer
// ---------------------------------------------------------------------------
module bus_tx_seq_test
    import bus_test_pkg::*;
#(
    parameter int NUM_BYTES   = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_100mhz,
    input  logic             reset_n,
    input  logic             bus_clk,
    inout  wire  [BUS_W-1:0] bus_data,
    input  logic             bus_rnw,
    output logic [3:0]       led_out
);

    localparam int                CNT_W    = $clog2(NUM_BYTES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NUM_BYTES - 1);

    state_e           state_q, state_d;
    logic [BUS_W-1:0] data_out_q, data_out_d;
    logic [BUS_W-1:0] csum_q, csum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       led_q;
    logic [1:0]       done_d;
    logic             abort_d;

    logic             rnw_s;
    logic [BUS_W-1:0] data_s;
    logic             rise;
    logic             fall;
    logic             write_rise;
    logic             read_fall;

    // The enable comes from the raw pin, so the bus is released on the same
    // cycle the RPI turns it around rather than SYNC_STAGES cycles later.
    assign bus_data = bus_rnw ? data_out_q : {BUS_W{1'bz}};

    bus_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .W           (BUS_W)
    ) u_sync (
        .clk_i      (clk_100mhz),
        .rst_n_i    (reset_n),
        .bus_clk_i  (bus_clk),
        .bus_rnw_i  (bus_rnw),
        .bus_data_i (bus_data),
        .rnw_s_o    (rnw_s),
        .data_s_o   (data_s),
        .rise_o     (rise),
        .fall_o     (fall)
    );

    // A write is latched on the strobe's rising edge. A read advances on its
    // falling edge, after the RPI has sampled during the high phase.
    assign write_rise = rise & ~rnw_s;
    assign read_fall  = fall & rnw_s;

    always_comb begin
        state_d    = state_q;
        data_out_d = data_out_q;
        csum_d     = csum_q;
        cnt_d      = cnt_q;
        done_d     = led_q[LED_CNT_HI:LED_CNT_LO];
        abort_d    = led_q[LED_ABORT];

        if (write_rise) begin
            // A new seed restarts the transfer from any state. If it arrives
            // mid-transfer, it is recorded as an abort.
            if (state_q != ST_IDLE) begin
                abort_d = 1'b1;
            end
            state_d    = ST_SEND;
            data_out_d = data_s;
            cnt_d      = '0;
            csum_d     = '0;
        end else if (read_fall) begin
            case (state_q)
                ST_SEND: begin
                    csum_d = csum_q + data_out_q;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        data_out_d = csum_q + data_out_q;
                        state_d    = ST_CSUM;
                    end else begin
                        data_out_d = data_out_q + BUS_W'(1);
                    end
                end
                ST_CSUM: begin
                    done_d  = done_d + 2'd1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            data_out_q <= '0;
            csum_q     <= '0;
            cnt_q      <= '0;
            led_q      <= '0;
        end else begin
            state_q                        <= state_d;
            data_out_q                     <= data_out_d;
            csum_q                         <= csum_d;
            cnt_q                          <= cnt_d;
            led_q[LED_CNT_HI:LED_CNT_LO]   <= done_d;
            led_q[LED_ABORT]               <= abort_d;
            led_q[LED_BUSY]                <= (state_d != ST_IDLE);
        end
    end

    assign led_out = led_q;

endmodule

// File: tb/tb_bus_tx_seq_test.sv
module tb_bus_tx_seq_test;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] bclk = 3'b000;
    logic [2:0] brnw = 3'b000;
    logic [2:0] den = 3'b111;
    logic [7:0] dval [3];
    wire  [7:0] bd0, bd1, bd2;
    wire  [3:0] led0, led1, led2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign bd0 = den[0] ? dval[0] : 8'hzz;
    assign bd1 = den[1] ? dval[1] : 8'hzz;
    assign bd2 = den[2] ? dval[2] : 8'hzz;

    bus_tx_seq_test #(.NUM_BYTES(4), .SYNC_STAGES(2)) u_dut0 (
        .clk_100mhz (clk), .reset_n (rst_n), .bus_clk (bclk[0]),
        .bus_data (bd0), .bus_rnw (brnw[0]), .led_out (led0));
    bus_tx_seq_test #(.NUM_BYTES(256), .SYNC_STAGES(2)) u_dut1 (
        .clk_100mhz (clk), .reset_n (rst_n), .bus_clk (bclk[1]),
        .bus_data (bd1), .bus_rnw (brnw[1]), .led_out (led1));
    bus_tx_seq_test #(.NUM_BYTES(1), .SYNC_STAGES(2)) u_dut2 (
        .clk_100mhz (clk), .reset_n (rst_n), .bus_clk (bclk[2]),
        .bus_data (bd2), .bus_rnw (brnw[2]), .led_out (led2));

    // Reference model: one transfer is seed..seed+N-1 followed by their sum.
    int         m_nb [3] = '{4, 256, 1};
    logic       m_busy [3];
    logic       m_abort [3];
    int         m_pos [3];
    int         m_done [3];
    logic [7:0] m_seed [3];
    logic [7:0] m_last [3];

    function automatic logic [7:0] m_present(int d);
        int n;
        n = m_nb[d];
        if (!m_busy[d]) return m_last[d];
        if (m_pos[d] < n) return 8'(int'(m_seed[d]) + m_pos[d]);
        return 8'(n * int'(m_seed[d]) + (n * (n - 1)) / 2);
    endfunction

    function automatic logic [3:0] m_led(int d);
        return {m_busy[d], m_abort[d], 2'(m_done[d])};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 3; i++) begin
            m_busy[i] = 1'b0; m_abort[i] = 1'b0; m_pos[i] = 0;
            m_done[i] = 0; m_seed[i] = 8'h00; m_last[i] = 8'h00;
        end
    endtask

    function automatic logic [7:0] get_bd(int d);
        case (d)
            0: return bd0;
            1: return bd1;
            default: return bd2;
        endcase
    endfunction

    function automatic logic [3:0] get_led(int d);
        case (d)
            0: return led0;
            1: return led1;
            default: return led2;
        endcase
    endfunction

    task automatic check(string name, int d, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(int d, logic [7:0] seed);
        @(negedge clk);
        brnw[d] = 1'b0; den[d] = 1'b1; dval[d] = seed;
        wait_cyc(6);
        bclk[d] = 1'b1;
        wait_cyc(6);
        bclk[d] = 1'b0;
        wait_cyc(6);
        if (m_busy[d]) m_abort[d] = 1'b1;
        m_busy[d] = 1'b1; m_seed[d] = seed; m_pos[d] = 0;
        check("led_after_write", d, 32'(get_led(d)), 32'(m_led(d)));
    endtask

    task automatic do_read(int d, int hold, output logic [7:0] got);
        logic [7:0] exp;
        @(negedge clk);
        den[d] = 1'b0; brnw[d] = 1'b1;
        wait_cyc(6);
        got = get_bd(d);
        exp = m_present(d);
        check("read_byte", d, 32'(got), 32'(exp));
        bclk[d] = 1'b1;
        wait_cyc(hold);
        bclk[d] = 1'b0;
        wait_cyc(6);
        if (m_busy[d]) begin
            m_last[d] = exp;
            if (m_pos[d] == m_nb[d]) begin
                m_busy[d] = 1'b0;
                m_done[d]++;
            end else begin
                m_pos[d]++;
            end
        end
        check("led_after_read", d, 32'(get_led(d)), 32'(m_led(d)));
    endtask

    typedef struct {
        int          d;
        logic [7:0]  seed;
        int          nrd;
        logic [39:0] exp_b;
        logic [3:0]  exp_led;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] got;
        for (int i = 0; i < 3; i++) dval[i] = 8'h00;
        m_reset();

        vecs[0] = '{0, 8'h10, 5, 40'h46_13_12_11_10, 4'b0001};
        vecs[1] = '{0, 8'hFE, 5, 40'hFE_01_00_FF_FE, 4'b0010};
        vecs[2] = '{2, 8'h5A, 2, 40'h00_00_00_5A_5A, 4'b0001};
        vecs[3] = '{0, 8'h80, 2, 40'h00_00_00_81_80, 4'b1010};
        vecs[4] = '{0, 8'h40, 5, 40'h06_43_42_41_40, 4'b0111};

        wait_cyc(3);
        check("reset_led", 0, 32'(led0), 32'h0);
        check("reset_led", 1, 32'(led1), 32'h0);
        check("reset_led", 2, 32'(led2), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(2);
        do_read(0, 6, got);                    // idle read: data_out is 0 after reset

        for (int v = 0; v < 5; v++) begin
            do_write(vecs[v].d, vecs[v].seed);
            for (int i = 0; i < vecs[v].nrd; i++) begin
                do_read(vecs[v].d, 6, got);
                check("tbl_byte", vecs[v].d, 32'(got), 32'(vecs[v].exp_b[8*i +: 8]));
            end
            check("tbl_led", vecs[v].d, 32'(get_led(vecs[v].d)), 32'(vecs[v].exp_led));
        end

        do_read(2, 6, got);                    // idle read on NUM_BYTES=1 holds checksum
        check("idle_hold", 2, 32'(got), 32'h5A);

        do_write(1, 8'h00);
        for (int i = 0; i < 256; i++) begin
            do_read(1, 6, got);
            check("full_seq", 1, 32'(got), 32'(i));
        end
        do_read(1, 6, got);
        check("full_csum", 1, 32'(got), 32'h80);
        check("full_led", 1, 32'(led1), 32'h1);

        @(negedge clk);
        den[0] = 1'b0; brnw[0] = 1'b1;
        wait_cyc(6);
        check("drive_on_read", 0, 32'(bd0), 32'h06);
        @(negedge clk);
        brnw[0] = 1'b0; den[0] = 1'b1; dval[0] = 8'hA5;
        #1;
        check("release_on_write", 0, 32'(bd0), 32'hA5);

        do_write(0, 8'h20);
        do_read(0, 6, got);
        do_read(0, 1, got);                    // one-cycle strobe counts once
        do_read(0, 6, got);
        check("short_pulse_next", 0, 32'(got), 32'h22);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_led", 0, 32'(led0), 32'h0);
        check("async_reset_led", 1, 32'(led1), 32'h0);
        m_reset();
        wait_cyc(2);
        rst_n = 1'b1;
        do_write(0, 8'h33);
        do_read(0, 6, got);
        check("restart_byte0", 0, 32'(got), 32'h33);
        do_read(0, 6, got);
        check("restart_byte1", 0, 32'(got), 32'h34);
        check("restart_led", 0, 32'(led0), 32'h8);

        for (int k = 0; k < 60; k++) begin
            int d;
            d = ($urandom_range(0, 1) == 0) ? 0 : 2;
            if ($urandom_range(0, 4) == 0)
                do_write(d, 8'($urandom_range(0, 255)));
            else
                do_read(d, 6, got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
